// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants
package cpu_pkg;

   localparam int NREG = 32;
   localparam int DW   = 32;
   localparam int AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;
   localparam logic [AW-1:0] REG_RA   = 5'd31;

   // True when a live write-back targets the given register (never $0).
   function automatic logic wb_hits(input logic we, input logic [AW-1:0] waddr,
                                    input logic [AW-1:0] addr);
      return we && (waddr == addr) && (addr != REG_ZERO);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy bits for in-flight load destinations and operand stall
module reg_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic            ld_issue,
   input  logic [AW-1:0]   ld_addr,
   input  logic            rd1_en,
   input  logic [AW-1:0]   raddr1,
   input  logic            rd2_en,
   input  logic [AW-1:0]   raddr2,
   output logic            stall,
   output logic [NREG-1:0] busy_vec
);
   import cpu_pkg::*;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            hzd1;
   logic            hzd2;

   // The set is applied after the clear so a new load on the same register wins.
   always_comb begin
      busy_next = busy;
      if (we && waddr != REG_ZERO)
         busy_next[waddr] = 1'b0;
      if (ld_issue && ld_addr != REG_ZERO)
         busy_next[ld_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_next;
   end

   // A write-back landing this cycle is forwarded by the bypass, so it clears the hazard.
   always_comb begin
      hzd1  = rd1_en && busy[raddr1] && !wb_hits(we, waddr, raddr1);
      hzd2  = rd2_en && busy[raddr2] && !wb_hits(we, waddr, raddr2);
      stall = hzd1 | hzd2;
   end

   assign busy_vec = busy;

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x32 register file, two bypassed read ports, one write port, load scoreboard
module regfile_2r1w #(
   parameter int NREG = cpu_pkg::NREG,
   parameter int DW   = cpu_pkg::DW,
   parameter int AW   = cpu_pkg::AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic            rd1_en,
   input  logic [AW-1:0]   raddr1,
   output logic [DW-1:0]   rdata1,
   input  logic            rd2_en,
   input  logic [AW-1:0]   raddr2,
   output logic [DW-1:0]   rdata2,
   input  logic            ld_issue,
   input  logic [AW-1:0]   ld_addr,
   output logic            stall,
   output logic [NREG-1:0] busy_vec
);
   import cpu_pkg::*;

   logic [DW-1:0] regs [NREG];

   // Entry 0 is never written, so it holds its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we && waddr != REG_ZERO) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      if (raddr1 == REG_ZERO)
         rdata1 = '0;
      else if (wb_hits(we, waddr, raddr1))
         rdata1 = wdata;
   end

   always_comb begin
      rdata2 = regs[raddr2];
      if (raddr2 == REG_ZERO)
         rdata2 = '0;
      else if (wb_hits(we, waddr, raddr2))
         rdata2 = wdata;
   end

   reg_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .ld_issue (ld_issue),
      .ld_addr  (ld_addr),
      .rd1_en   (rd1_en),
      .raddr1   (raddr1),
      .rd2_en   (rd2_en),
      .raddr2   (raddr2),
      .stall    (stall),
      .busy_vec (busy_vec)
   );

endmodule
